// File: rtl/rsp_pkg.sv
// Shared definitions for the response-path blocks.
// Holds the default packet geometry and the packed structs used to slice
// routed packets and egress FIFO entries by field rather than by bit range.
package rsp_pkg;

    localparam int VDW = 37;
    localparam int DW  = 32;
    localparam int TTW = 2;
    localparam int ITW = VDW - DW - TTW;

    // Routed packet as it leaves the router: {init_tag, tgt_tag, data}
    typedef struct packed {
        logic [ITW-1:0] itag;
        logic [TTW-1:0] ttag;
        logic [DW-1:0]  data;
    } rsp_pkt_t;

    // What the egress buffer keeps per packet; the target tag is consumed
    // by the tag check and does not need to be stored.
    typedef struct packed {
        logic [ITW-1:0] itag;
        logic [DW-1:0]  data;
    } rsp_entry_t;

endpackage

// File: rtl/rsp_sync_fifo.sv
// Generic synchronous FIFO with a registered occupancy counter.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, wdata       - write strobe and data (caller guarantees !full)
//   pop               - read strobe (caller guarantees !empty)
//   rdata             - combinational read of the head entry
//   full, empty       - derived from the occupancy counter
//   count             - current occupancy, 0..DEPTH
module rsp_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers are exactly AW bits wide, so DEPTH being a power of two lets
    // them wrap from DEPTH-1 back to 0 without any compare logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; stale contents are never
    // observable because empty masks them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/rsp_xegress.sv
// Per-target egress buffer sitting on one T port of the response router.
// Buffers routed packets in a small FIFO so target-side backpressure does
// not stall the router arbiter, delivers {data, init_tag} to the consumer
// and raises a sticky flag when a packet's target tag is not this port.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   T_vld, T_pkt      - packet offered by the router
//   T_rdy             - buffer accepts this cycle (registered state only)
//   O_vld             - head entry valid toward the consumer
//   O_data, O_itag    - head entry payload and initiator tag
//   O_rdy             - consumer takes the head entry
//   count             - current occupancy
//   err_tag           - sticky target-tag mismatch flag
module rsp_xegress #(
    parameter int VDW    = 37,
    parameter int DW     = 32,
    parameter int TTW    = 2,
    parameter int TGT_ID = 0,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     T_vld,
    input  logic [VDW-1:0]           T_pkt,
    output logic                     T_rdy,
    output logic                     O_vld,
    output logic [DW-1:0]            O_data,
    output logic [VDW-DW-TTW-1:0]    O_itag,
    input  logic                     O_rdy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_tag
);

    import rsp_pkg::*;

    rsp_pkt_t   pkt;
    rsp_entry_t wr_entry;
    rsp_entry_t rd_entry;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       tag_bad;

    assign pkt      = rsp_pkt_t'(T_pkt);
    assign wr_entry = '{itag: pkt.itag, data: pkt.data};

    // T_rdy is built only from registered state and rst so the router's
    // arbiter never sees a combinational path through O_rdy or T_vld.
    // While full it stays low even if the consumer pops this cycle.
    assign T_rdy = !full && !rst;
    assign O_vld = !empty;
    assign push  = T_vld && T_rdy;
    assign pop   = O_vld && O_rdy;

    rsp_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(rsp_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign O_data = rd_entry.data;
    assign O_itag = rd_entry.itag;

    // A misrouted packet is still stored and delivered; the flag only
    // records that it happened and holds until reset.
    assign tag_bad = (pkt.ttag != TTW'(TGT_ID));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_tag <= 1'b0;
        end else if (push && tag_bad) begin
            err_tag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rsp_xegress.sv
// Directed bench for rsp_xegress: the stimulus process keeps a small model
// of occupancy and the sticky tag flag and queues the expected payload of
// every accepted packet; a separate monitor compares the head entry against
// that queue whenever O_vld is high and retires it on O_rdy.
module tb_rsp_xegress;

    localparam int DEPTH = 4;
    localparam int TGT   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        T_vld = 1'b0;
    logic [36:0] T_pkt = '0;
    logic        T_rdy;
    logic        O_vld;
    logic [31:0] O_data;
    logic [2:0]  O_itag;
    logic        O_rdy = 1'b0;
    logic [2:0]  count;
    logic        err_tag;

    int          asserts  = 0;
    int          failures = 0;
    logic [34:0] expq[$];
    int          mcount = 0;
    logic        merr   = 1'b0;

    rsp_xegress #(
        .VDW    (37),
        .DW     (32),
        .TTW    (2),
        .TGT_ID (TGT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .T_vld   (T_vld),
        .T_pkt   (T_pkt),
        .T_rdy   (T_rdy),
        .O_vld   (O_vld),
        .O_data  (O_data),
        .O_itag  (O_itag),
        .O_rdy   (O_rdy),
        .count   (count),
        .err_tag (err_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] mk(input logic [2:0] it, input logic [1:0] tt,
                                       input logic [31:0] d);
        return {it, tt, d};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, check the
    // registered outputs at the falling edge against the model, then advance
    // the model by what the coming edge will do.
    task automatic applyStimulus(input logic r, input logic v, input logic [36:0] p,
                                 input logic ordy, output logic accepted);
        logic mpush;
        logic mpop;
        @(posedge clk);
        #1;
        rst   = r;
        T_vld = v;
        T_pkt = p;
        O_rdy = ordy;
        @(negedge clk);
        checkOutput("count",   32'(count),   32'(mcount));
        checkOutput("T_rdy",   32'(T_rdy),   32'(!r && (mcount < DEPTH)));
        checkOutput("O_vld",   32'(O_vld),   32'(mcount > 0));
        checkOutput("err_tag", 32'(err_tag), 32'(merr));
        mpush    = !r && v && (mcount < DEPTH);
        mpop     = !r && (mcount > 0) && ordy;
        accepted = mpush;
        if (r) begin
            mcount = 0;
            merr   = 1'b0;
            expq.delete();
        end else begin
            if (mpush) begin
                expq.push_back({p[36:34], p[31:0]});
                if (p[33:32] != 2'(TGT)) merr = 1'b1;
            end
            mcount = mcount + int'(mpush) - int'(mpop);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [36:0] p, input logic ordy);
        logic acc;
        applyStimulus(r, v, p, ordy, acc);
    endtask

    // Monitor: the head entry must match the oldest outstanding packet for
    // every cycle it is presented, which also covers stability under stall.
    always @(negedge clk) begin
        if (!rst && O_vld) begin
            if (expq.size() == 0) begin
                asserts++;
                failures++;
                $display("[TB] FAIL unexpected_output: got data 0x%0h, expected no output", O_data);
            end else begin
                checkOutput("O_data", O_data, expq[0][31:0]);
                checkOutput("O_itag", 32'(O_itag), 32'(expq[0][34:32]));
                if (O_rdy) void'(expq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        logic ordy;
        int   n;
        int   guard;

        $display("[TB] reset");
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);

        $display("[TB] single packet");
        step(0, 1, mk(3'd3, 2'(TGT), 32'hDEADBEEF), 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        $display("[TB] fill and backpressure");
        for (int i = 0; i < 4; i++) step(0, 1, mk(3'(i), 2'(TGT), 32'hA000_0000 + 32'(i)), 0);
        step(0, 1, mk(3'd7, 2'(TGT), 32'hBAD0_0001), 0);
        step(0, 1, mk(3'd7, 2'(TGT), 32'hBAD0_0001), 0);
        step(0, 1, mk(3'd7, 2'(TGT), 32'hBAD0_0001), 1);
        step(0, 1, mk(3'd5, 2'(TGT), 32'hA000_0004), 0);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

        $display("[TB] wrap and ordering");
        n     = 0;
        guard = 0;
        ordy  = 1'b1;
        while (n < 10 && guard < 100) begin
            applyStimulus(0, 1, mk(3'(n), 2'(TGT), 32'(n)), ordy, acc);
            if (acc) n++;
            ordy = !ordy;
            guard++;
        end
        checkOutput("wrap_accepted", 32'(n), 32'd10);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

        $display("[TB] simultaneous push/pop at count 2");
        step(0, 1, mk(3'd1, 2'(TGT), 32'h0000_0100), 0);
        step(0, 1, mk(3'd2, 2'(TGT), 32'h0000_0101), 0);
        for (int i = 0; i < 3; i++) step(0, 1, mk(3'(i + 3), 2'(TGT), 32'h0000_0102 + 32'(i)), 1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

        $display("[TB] tag mismatch");
        step(0, 1, mk(3'd6, 2'd2, 32'h1234_5678), 1);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) step(0, 1, mk(3'(i), 2'(TGT), 32'hC000_0000 + 32'(i)), 0);
        step(0, 0, '0, 0);
        step(1, 1, mk(3'd4, 2'(TGT), 32'hC0DE_0000), 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        checkOutput("drain", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
